inst_fetch_queue: RTL and testbench

//  Instruction fetch queue between the PC register/instruction memory and the ID stage.

---
 rtl/inst_fetch_queue_pkg.sv | 23 ++
 rtl/inst_fetch_queue_if.sv | 32 +++
 rtl/inst_fetch_queue.sv | 68 ++++++
 tb/tb_inst_fetch_queue.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and the queue entry record for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Entry shown to decode when nothing is queued.
    function automatic fetch_entry_t empty_entry();
        fetch_entry_t e;
        e.pc   = '0;
        e.pc4  = '0;
        e.inst = NOP_INST;
        return e;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and decode-side signals of the instruction fetch queue.
interface inst_fetch_queue_if
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
);

    logic            In_Valid;
    logic [XLEN-1:0] In_PC;
    logic [XLEN-1:0] In_PC4;
    logic [XLEN-1:0] In_Inst;
    logic            Keep;
    logic            Out_Valid;
    logic            Out_Ready;
    logic [XLEN-1:0] Out_PC;
    logic [XLEN-1:0] Out_PC4;
    logic [XLEN-1:0] Out_Inst;
    logic            Flush;
    logic [PTR_W:0]  Count;

    modport master (
        output In_Valid, In_PC, In_PC4, In_Inst, Out_Ready, Flush,
        input  Keep, Out_Valid, Out_PC, Out_PC4, Out_Inst, Count
    );

    modport slave (
        input  In_Valid, In_PC, In_PC4, In_Inst, Out_Ready, Flush,
        output Keep, Out_Valid, Out_PC, Out_PC4, Out_Inst, Count
    );

endinterface

// File: rtl/inst_fetch_queue.sv
// First-word-fall-through queue of fetched {PC, PC4, Inst} between IF and ID,
// with back-pressure (Keep) to the PC register and wrong-path flush.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_queue_if.slave  q
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    fetch_entry_t     entry_q [DEPTH];
    fetch_entry_t     head_entry;

    logic full, empty, enq_fire, deq_fire;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign enq_fire = q.In_Valid & ~full & ~q.Flush;
    assign deq_fire = ~empty & q.Out_Ready & ~q.Flush;

    always_comb begin
        head_d  = head_q + PTR_W'(deq_fire);
        tail_d  = tail_q + PTR_W'(enq_fire);
        count_d = count_q + {{PTR_W{1'b0}}, enq_fire} - {{PTR_W{1'b0}}, deq_fire};
    end

    // Reset and flush both discard every queued entry.
    always_ff @(posedge clk) begin
        if (!rst || q.Flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left uninitialised; Count alone decides what is visible.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (rst && enq_fire && tail_q == PTR_W'(gi)) begin
                entry_q[gi].pc   <= q.In_PC;
                entry_q[gi].pc4  <= q.In_PC4;
                entry_q[gi].inst <= q.In_Inst;
            end
        end
    end

    assign head_entry = empty ? empty_entry() : entry_q[head_q];

    assign q.Out_Valid = ~empty;
    assign q.Out_PC    = head_entry.pc;
    assign q.Out_PC4   = head_entry.pc4;
    assign q.Out_Inst  = head_entry.inst;
    assign q.Keep      = full | q.Flush;
    assign q.Count     = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed table-driven bench for inst_fetch_queue plus hand-written full-queue corner case.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.DEPTH(DEPTH), .PTR_W(PTR_W)) ifc ();

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .q   (ifc)
    );

    typedef struct {
        logic        chk;
        logic        rst_n;
        logic        in_valid;
        logic [31:0] in_pc;
        logic        out_ready;
        logic        flush;
        int          exp_count;
        logic        exp_valid;
        logic        exp_keep;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Instruction word the bench associates with each PC.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1300_0013;
    endfunction

    function automatic vec_t mk(input logic chk, input logic rst_n, input logic in_valid,
                                input logic [31:0] in_pc, input logic out_ready,
                                input logic flush, input int exp_count,
                                input logic exp_valid, input logic exp_keep,
                                input logic [31:0] exp_pc);
        vec_t v;
        v.chk = chk; v.rst_n = rst_n; v.in_valid = in_valid; v.in_pc = in_pc;
        v.out_ready = out_ready; v.flush = flush; v.exp_count = exp_count;
        v.exp_valid = exp_valid; v.exp_keep = exp_keep; v.exp_pc = exp_pc;
        return v;
    endfunction

    task automatic drive(input logic in_valid, input logic [31:0] pc,
                         input logic out_ready, input logic flush);
        ifc.In_Valid  = in_valid;
        ifc.In_PC     = pc;
        ifc.In_PC4    = pc + 32'd4;
        ifc.In_Inst   = inst_of(pc);
        ifc.Out_Ready = out_ready;
        ifc.Flush     = flush;
    endtask

    task automatic cmp(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input int exp_count, input logic exp_valid,
                             input logic exp_keep, input logic [31:0] exp_pc);
        logic [31:0] e_pc4, e_inst;
        e_pc4  = exp_valid ? exp_pc + 32'd4 : 32'h0;
        e_inst = exp_valid ? inst_of(exp_pc) : NOP_INST;
        cmp("count", idx, 32'(ifc.Count), 32'(exp_count));
        cmp("out_valid", idx, 32'(ifc.Out_Valid), 32'(exp_valid));
        cmp("keep", idx, 32'(ifc.Keep), 32'(exp_keep));
        cmp("out_pc", idx, ifc.Out_PC, exp_valid ? exp_pc : 32'h0);
        cmp("out_pc4", idx, ifc.Out_PC4, e_pc4);
        cmp("out_inst", idx, ifc.Out_Inst, e_inst);
        $display("[TB] vec %0d: count=%0d valid=%0b keep=%0b pc=%h",
                 idx, ifc.Count, ifc.Out_Valid, ifc.Keep, ifc.Out_PC);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0));
        // fill to full, fifth fetch dropped
        vecs.push_back(mk(1, 1, 1, 32'h0040_0000, 0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 1, 32'h0040_0004, 0, 0, 1, 1, 0, 32'h0040_0000));
        vecs.push_back(mk(1, 1, 1, 32'h0040_0008, 0, 0, 2, 1, 0, 32'h0040_0000));
        vecs.push_back(mk(1, 1, 1, 32'h0040_000C, 0, 0, 3, 1, 0, 32'h0040_0000));
        vecs.push_back(mk(1, 1, 1, 32'h0040_0010, 0, 0, 4, 1, 1, 32'h0040_0000));
        vecs.push_back(mk(1, 1, 0, 32'h0, 0, 0, 4, 1, 1, 32'h0040_0000));
        // drain
        vecs.push_back(mk(1, 1, 0, 32'h0, 1, 0, 4, 1, 1, 32'h0040_0000));
        vecs.push_back(mk(1, 1, 0, 32'h0, 1, 0, 3, 1, 0, 32'h0040_0004));
        vecs.push_back(mk(1, 1, 0, 32'h0, 1, 0, 2, 1, 0, 32'h0040_0008));
        vecs.push_back(mk(1, 1, 0, 32'h0, 1, 0, 1, 1, 0, 32'h0040_000C));
        vecs.push_back(mk(1, 1, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0));
        // streaming across pointer wrap: head shows previous cycle's PC
        vecs.push_back(mk(1, 1, 1, 32'h0000_0500, 1, 0, 0, 0, 0, 32'h0));
        for (int i = 1; i <= 10; i++)
            vecs.push_back(mk(1, 1, 1, 32'h500 + 32'(4*i), 1, 0, 1, 1, 0,
                              32'h500 + 32'(4*(i-1))));
        vecs.push_back(mk(1, 1, 0, 32'h0, 1, 0, 1, 1, 0, 32'h0000_0528));
        vecs.push_back(mk(1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0));
        // flush with same-cycle enqueue
        vecs.push_back(mk(1, 1, 1, 32'h0000_0600, 0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 1, 32'h0000_0604, 0, 0, 1, 1, 0, 32'h0000_0600));
        vecs.push_back(mk(1, 1, 1, 32'h0000_0608, 0, 0, 2, 1, 0, 32'h0000_0600));
        vecs.push_back(mk(1, 1, 1, 32'h0000_060C, 1, 1, 3, 1, 1, 32'h0000_0600));
        vecs.push_back(mk(1, 1, 1, 32'h0040_0100, 0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0, 0, 0, 1, 1, 0, 32'h0040_0100));
        vecs.push_back(mk(1, 1, 0, 32'h0, 1, 0, 1, 1, 0, 32'h0040_0100));
        vecs.push_back(mk(1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0));
        // reset mid-stream
        vecs.push_back(mk(1, 1, 1, 32'h0000_0700, 0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 1, 32'h0000_0704, 0, 0, 1, 1, 0, 32'h0000_0700));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0708, 0, 0, 2, 1, 0, 32'h0000_0700));
        vecs.push_back(mk(1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0));

        rst = 1'b0;
        drive(0, 32'h0, 0, 0);
        tick();

        foreach (vecs[i]) begin
            rst = vecs[i].rst_n;
            drive(vecs[i].in_valid, vecs[i].in_pc, vecs[i].out_ready, vecs[i].flush);
            #1;
            if (vecs[i].chk)
                check_all(i, vecs[i].exp_count, vecs[i].exp_valid,
                          vecs[i].exp_keep, vecs[i].exp_pc);
            tick();
        end

        // Full queue with simultaneous fetch and consume: enqueue refused, count drops.
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h800 + 32'(4*i), 0, 0);
            tick();
        end
        drive(1, 32'h0000_0810, 1, 0);
        #1;
        check_all(100, 4, 1, 1, 32'h0000_0800);
        tick();
        drive(0, 32'h0, 1, 0);
        #1;
        check_all(101, 3, 1, 0, 32'h0000_0804);
        tick();
        #1;
        check_all(102, 2, 1, 0, 32'h0000_0808);
        tick();
        #1;
        check_all(103, 1, 1, 0, 32'h0000_080C);
        tick();
        drive(0, 32'h0, 0, 0);
        #1;
        check_all(104, 0, 0, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
